// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder
//   WIDTH-bit add/subtract split into STAGES carry chunks. The carry between
//   chunks is registered, and a valid/ready handshake gives full backpressure.
//   Stage k adds chunk k of A and B' (B' = sub ? ~b : b) using the carry from
//   stage k-1. Operands travel down the pipe with the beat. Finished low sum
//   chunks collect in an accumulator, so every chunk of a result comes out
//   together. Latency is STAGES cycles and throughput is one beat per cycle.
//
// Ports
//   clk, rst             single rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand beat handshake (in_ready is combinational from out_ready)
//   a, b, cin, sub       operands; sub=1 computes a-b (cin ignored)
//   out_valid / out_ready result beat handshake
//   sum, cout            result and carry-out of MSB (sub: 1 = no borrow)
//   ovf                  signed overflow; exists only if PIPE_ADDER_OVF_EN is defined
//
// Build option: `define PIPE_ADDER_OVF_EN adds the ovf port and its logic.
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int unsigned CHUNK = WIDTH / STAGES;
    // Number of operand-forwarding registers (the last stage needs none).
    localparam int unsigned NR    = (STAGES > 1) ? STAGES - 1 : 1;

    if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic [STAGES-1:0] v;             // stage valid bits
    logic [STAGES-1:0] cy;            // registered carry out of each chunk
    logic [STAGES-1:0] adv;           // stage may load this cycle
    logic [WIDTH-1:0]  acc [STAGES];  // sum chunks 0..k finished, upper chunks zero
    logic [WIDTH-1:0]  ra  [NR];      // A forwarded to the next stage
    logic [WIDTH-1:0]  rb  [NR];      // B' forwarded to the next stage

    // A stage can load when the next stage can load or when the stage is empty.
    // This propagates backpressure from the output toward the input within one cycle.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = out_ready | ~v[STAGES-1];
        for (int unsigned i = 0; i + 1 < STAGES; i++) begin
            adv[STAGES-2-i] = adv[STAGES-1-i] | ~v[STAGES-2-i];
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] acc_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK-1:0] ca;
        logic [CHUNK-1:0] cb;
        logic [CHUNK-1:0] cs;
        logic             co;

        if (k == 0) begin : g_head
            assign a_in   = a;
            assign b_in   = sub ? ~b : b;
            assign acc_in = '0;
            assign c_in   = sub | cin;
            assign v_in   = in_valid;
        end else begin : g_body
            assign a_in   = ra[k-1];
            assign b_in   = rb[k-1];
            assign acc_in = acc[k-1];
            assign c_in   = cy[k-1];
            assign v_in   = v[k-1];
        end

        assign ca = CHUNK'(a_in >> (k * CHUNK));
        assign cb = CHUNK'(b_in >> (k * CHUNK));
        assign {co, cs} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                v[k]   <= 1'b0;
                cy[k]  <= 1'b0;
                acc[k] <= '0;
            end else if (adv[k]) begin
                v[k]   <= v_in;
                cy[k]  <= co;
                acc[k] <= acc_in | (WIDTH'(cs) << (k * CHUNK));
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            always_ff @(posedge clk) begin
                if (adv[k]) begin
                    ra[k] <= a_in;
                    rb[k] <= b_in;
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            // Carry into the MSB is recovered from the MSB sum bit.
            logic msb_cin;
            assign msb_cin = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ cs[CHUNK-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf <= 1'b0;
                end else if (adv[k]) begin
                    ovf <= msb_cin ^ co;
                end
            end
        end
`endif
    end

    assign out_valid = v[STAGES-1];
    assign sum       = acc[STAGES-1];
    assign cout      = cy[STAGES-1];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
module tb_pipelined_ripple_adder;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         lat;
        int unsigned  t;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned pop_cnt = 0;
    int unsigned last_pop = 0;
    logic        lat_chk = 1'b0;
    logic        rand_rdy = 1'b0;

    // Directed vectors with hand-computed results.
    logic [15:0] da [8] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'h0001};
    logic [15:0] db [8] = '{16'h1111, 16'h0001, 16'h0000, 16'h0007, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
    logic        dc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        dsb[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ds [8] = '{16'h2345, 16'h0000, 16'h0100, 16'hFFFE, 16'h0002, 16'h8000, 16'h7FFF, 16'h0002};
    logic        dco[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        dov[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic, unsigned for sum/cout, signed for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        exp_t e;
        int   ux = x;
        int   uy = y;
        int   sx = $signed(x);
        int   sy = $signed(y);
        int   u;
        int   r;
        if (sb) begin
            u = ux + 65536 - uy;
            r = sx - sy;
        end else begin
            u = ux + uy + (ci ? 1 : 0);
            r = sx + sy + (ci ? 1 : 0);
        end
        e.s   = W'(u % 65536);
        e.c   = (u >= 65536);
        e.o   = (r > 32767) || (r < -32768);
        e.lat = 1'b0;
        e.t   = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks that a stalled output holds.
    logic         held = 1'b0;
    logic [W-1:0] hs;
    logic         hc;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(sum), 32'(hs));
                chk("hold_cout", 32'(cout), 32'(hc));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got sum=%0h want no beat (cycle %0d)", sum, cyc);
                end else begin
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("cout", 32'(cout), 32'(e.c));
`ifdef PIPE_ADDER_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.o));
`endif
                    if (e.lat) chk("latency", cyc - e.t, 32'(S));
                end
                pop_cnt++;
                last_pop = cyc;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                hs   = sum;
                hc   = cout;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Random consumer backpressure while rand_rdy is set.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Drive one beat; called #1 after a posedge and returns #1 after the accepting posedge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb,
                        input logic use_exp, input exp_t ex);
        exp_t        e;
        int unsigned n = 0;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: got in_ready=0 want 1 within 200 cycles");
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        e = use_exp ? ex : model(x, y, ci, sb);
        e.lat = lat_chk;
        e.t   = cyc;
        q.push_back(e);
        acc_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int unsigned n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk(nm, 32'(q.size()), 32'd0);
    endtask

    task automatic send_rand();
        logic [W-1:0] x = W'($urandom);
        logic [W-1:0] y = W'($urandom);
        exp_t         dummy;
        if ($urandom_range(0, 4) == 0) x = 16'hFFFF;
        if ($urandom_range(0, 4) == 0) y = 16'h0001;
        dummy = model(x, y, 1'b0, 1'b0);
        send(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, dummy);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        ex;
        int unsigned acc0;
        int unsigned pop0;
        int unsigned r0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_ADDER_OVF_EN
        chk("reset_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk); #1;

        // Directed vectors, no backpressure: exact latency checked.
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            ex.s = ds[i]; ex.c = dco[i]; ex.o = dov[i]; ex.lat = 1'b0; ex.t = 0;
            send(da[i], db[i], dc[i], dsb[i], 1'b1, ex);
        end
        drain("directed_drain");
        lat_chk = 1'b0;

        // Eight back-to-back beats into a blocked output.
        out_ready = 1'b0;
        acc0 = acc_cnt;
        fork
            begin
                for (int unsigned i = 0; i < 8; i++) send_rand();
            end
        join_none
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", acc_cnt - acc0, 32'(S));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        r0   = cyc;
        pop0 = pop_cnt;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("bp_drained", pop_cnt - pop0, 32'd8);
        chk("bp_no_gaps", last_pop - r0, 32'd7);

        // Fill the pipe, then reset mid-stream; nothing in flight may emerge afterwards.
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) send_rand();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int unsigned i = 0; i < 6; i++) send_rand();
        drain("post_reset_drain");

        // Random traffic with random gaps and random backpressure.
        rand_rdy = 1'b1;
        for (int unsigned i = 0; i < 200; i++) begin
            send_rand();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
